// File: rtl/sa_ram_fifo_ctrl_128x128.sv
// FIFO controller around a 128x128 two-port SA RAM with a registered read
// address; a 2-entry prefetch buffer hides the one-cycle read latency.
module sa_ram_fifo_ctrl_128x128 #(
    parameter int unsigned DW       = 128,
    parameter int unsigned AW       = 7,
    parameter int unsigned OB_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_pd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_pd,
    output logic [7:0]    fifo_cnt,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    input  logic [DW-1:0] ram_dout,
    input  logic [31:0]   pwrbus_ram_pd_in,
    output logic [31:0]   pwrbus_ram_pd
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(1 << AW);
    localparam logic [2:0]  OB_LIM   = 3'(OB_DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic          rd_inflight_q, rd_inflight_d;
    logic [1:0]    ob_cnt_q, ob_cnt_d;
    logic          ob_head_q, ob_head_d;
    logic          in_ready_q, in_ready_d;
    logic [DW-1:0] ob_mem_q [2];
    logic [DW-1:0] ob_mem_d [2];

    logic       push;
    logic       pop;
    logic       ob_tail;
    logic [2:0] ob_occ;

    always_comb begin
        push    = in_valid & in_ready_q;
        pop     = (ob_cnt_q != 2'd0) & out_ready;
        ob_occ  = {1'b0, ob_cnt_q} + {2'b00, rd_inflight_q};
        // A pop this cycle frees a buffer slot in time for the read issued now.
        ram_re  = (ram_cnt_q != '0) && (ob_occ < (OB_LIM + {2'b00, pop}));
        ob_tail = ob_head_q ^ ob_cnt_q[0];

        wr_ptr_d      = push   ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d      = ram_re ? rd_ptr_q + AW'(1) : rd_ptr_q;
        ram_cnt_d     = ram_cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, ram_re};
        rd_inflight_d = ram_re;
        in_ready_d    = ram_cnt_d < FULL_CNT;
        ob_cnt_d      = ob_cnt_q + {1'b0, rd_inflight_q} - {1'b0, pop};
        ob_head_d     = ob_head_q ^ pop;

        ob_mem_d = ob_mem_q;
        if (rd_inflight_q) begin
            ob_mem_d[ob_tail] = ram_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ram_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
            ob_cnt_q      <= '0;
            ob_head_q     <= 1'b0;
            in_ready_q    <= 1'b0;
            ob_mem_q[0]   <= '0;
            ob_mem_q[1]   <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ram_cnt_q     <= ram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            ob_cnt_q      <= ob_cnt_d;
            ob_head_q     <= ob_head_d;
            in_ready_q    <= in_ready_d;
            ob_mem_q[0]   <= ob_mem_d[0];
            ob_mem_q[1]   <= ob_mem_d[1];
        end
    end

    always_comb begin
        in_ready      = in_ready_q;
        out_valid     = ob_cnt_q != 2'd0;
        out_pd        = ob_mem_q[ob_head_q];
        ram_we        = push;
        ram_wa        = wr_ptr_q;
        ram_di        = push ? in_pd : '0;
        ram_ra        = rd_ptr_q;
        fifo_cnt      = 8'(ram_cnt_q) + 8'(rd_inflight_q) + 8'(ob_cnt_q);
        pwrbus_ram_pd = pwrbus_ram_pd_in;
    end

endmodule

// File: doc/sa_ram_fifo_ctrl_128x128.md
Name: sa_ram_fifo_ctrl_128x128

Overview:
- Initiator-side controller for the 128x128 two-port SA RAM model. The RAM has a registered read address, so dout is valid the cycle after re and holds while re stays low.
- Turns valid/ready push and pop streams into RAM write and read commands.
- Hides the one-cycle read latency with a 2-entry output prefetch buffer.
- Sits between a producer and consumer in the systolic-array data path, next to an instance of the RAM.

Parameters:
- DW, 128, data width; must match the RAM word width.
- AW, 7, address width; RAM depth is 2**AW = 128.
- OB_DEPTH, 2, output prefetch buffer entries; fixed at 2, no other value is supported.

Ports:
- clk  in  1  core clock; all logic on posedge.
- rstn  in  1  synchronous reset, active-low, sampled on posedge clk.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller accepts a word; push happens when in_valid & in_ready.
- in_pd  in  DW  push data.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer takes the word; pop happens when out_valid & out_ready.
- out_pd  out  DW  head word.
- fifo_cnt  out  8  total occupancy: RAM entries + read in flight + prefetch buffer entries; maximum 130.
- ram_wa  out  AW  RAM write address.
- ram_we  out  1  RAM write enable.
- ram_di  out  DW  RAM write data.
- ram_ra  out  AW  RAM read address.
- ram_re  out  1  RAM read enable.
- ram_dout  in  DW  RAM read data, valid the cycle after ram_re.
- pwrbus_ram_pd_in  in  32  power bus, passed through unchanged.
- pwrbus_ram_pd  out  32  connects to the RAM power bus.

Behaviour:
- Reset (rstn=0 at posedge):
  - wr_ptr, rd_ptr, ram_cnt, rd_inflight, ob_cnt, ob_head all go to 0.
  - Outputs: in_ready=0, out_valid=0, ram_we=0, ram_re=0, fifo_cnt=0.
  - out_pd, ram_wa, ram_ra, ram_di reset to 0.
  - Reset asserted mid-operation discards all data, including a read in flight. A capture is suppressed if its edge coincides with reset.
  - in_ready rises in the first cycle after rstn deasserts.
- Write path:
  - in_ready = (ram_cnt < 2**AW), driven from registered ram_cnt.
  - ram_we = in_valid & in_ready (combinational), ram_wa = wr_ptr, ram_di = in_pd.
  - wr_ptr increments on push and wraps 127 -> 0.
- Read issue:
  - ram_re = (ram_cnt != 0) & (ob_cnt + rd_inflight - pop < OB_DEPTH), where pop = out_valid & out_ready.
  - ram_ra = rd_ptr; rd_ptr increments on ram_re and wraps 127 -> 0.
  - rd_inflight <= ram_re.
- ram_cnt update: ram_cnt <= ram_cnt + push - ram_re. A simultaneous push and read leaves it unchanged.
  - A RAM slot is freed at issue. A write to that slot lands at the earliest one edge later, which is the capture edge; capture samples the pre-write value.
- Capture:
  - When rd_inflight=1, ram_dout is written into the prefetch buffer at the tail.
  - The prefetch buffer is a 2-entry circular buffer; ob_cnt <= ob_cnt + rd_inflight - pop.
- Output:
  - out_valid = (ob_cnt != 0); out_pd = buffer[ob_head]; ob_head toggles on pop.
  - out_pd holds stable while out_valid & !out_ready.
- Latency:
  - Push accepted at edge E0 -> ram_re in cycle after E0 (RAM otherwise empty) -> captured at E2 -> out_valid high after E2.
  - Sustained throughput is 1 word/cycle in and out.
- Simultaneous events:
  - Push while full is impossible (in_ready=0).
  - Pop and capture in the same cycle: ob_cnt unchanged.
  - Pop, push and read issue in the same cycle are all legal.
- fifo_cnt = ram_cnt + rd_inflight + ob_cnt.
- Ordering: strict FIFO.
- pwrbus_ram_pd = pwrbus_ram_pd_in.

Test Plan:
- Reset then single word: push 0xA5..A5 at cycle 0, out_ready=1. Required: ram_we=1 with ram_wa=0 in cycle 0; ram_re=1 with ram_ra=0 in cycle 1; out_valid=1 with out_pd=0xA5..A5 in cycle 3; fifo_cnt returns to 0.
- Fill with out_ready=0: push words 0..129. Required: out_valid=1, ob_cnt=2, ram_cnt=128, in_ready=0 after 130 accepts, fifo_cnt=130. Then one pop: in_ready=1 within 2 cycles.
- Streaming: in_valid=1 and out_ready=1 continuously for 300 words with an incrementing pattern. Required: outputs in order with no gaps after the initial 3-cycle fill, and wr_ptr/rd_ptr wrap 127->0 twice.
- Backpressure: out_ready toggles 1,0,0,1 repeatedly. Required: out_pd stable while stalled, no drop or duplicate, ram_re never issued while ob_cnt + rd_inflight = 2 without a pop.
- Reset mid-operation: assert rstn=0 with 50 words stored and ram_re=1 in that cycle. Required: next cycle out_valid=0 and fifo_cnt=0. After release, pushing 0x1 produces only 0x1.
- Slot reuse: full RAM with rd_ptr=5. Pop so that ram_re reads address 5, then push 0xFF into address 5 on the next cycle. Required: the captured word is the old address-5 data; 0xFF emerges 128 words later.
